wb_burst_master: RTL
====================

WB_BURST_MASTER -- requirements
Module: wb_burst_master

Interface
REQ-001 Parameter DW, default 32: Wishbone data width in bits; byte lanes SW = DW/8.
REQ-002 Parameter AW, default 32: Wishbone byte address width.
REQ-003 Parameter LEN_W, default 8: burst-length field width.
REQ-004 Parameter TIMEOUT, default 1024: maximum cycles allowed waiting for one ack.
REQ-005 Parameter SEED, default 32'hA5A5_0000: data-pattern XOR seed.
REQ-006 Clock and reset: one clock, wb_clk_i; reset is asynchronous and active-low, RESETN.
REQ-007 Port wb_clk_i, in, 1: system clock.
REQ-008 Port RESETN, in, 1: async active-low reset.
REQ-009 Port cmd_valid_i, in, 1: burst command offered.
REQ-010 Port cmd_ready_o, out, 1: command accepted when high with cmd_valid_i.
REQ-011 Port cmd_we_i, in, 1: 1 = write burst, 0 = read-and-check burst.
REQ-012 Port cmd_addr_i, in, AW: start byte address.
REQ-013 Port cmd_len_i, in, LEN_W: beats minus one.
REQ-014 Ports wb_cyc_o, wb_stb_o, wb_we_o: out, 1 each; Wishbone classic master controls.
REQ-015 Port wb_addr_o, out, AW: byte address.
REQ-016 Port wb_sel_o, out, SW: byte selects.
REQ-017 Port wb_dat_o, out, DW: write data.
REQ-018 Port wb_dat_i, in, DW: read data.
REQ-019 Port wb_ack_i, in, 1: slave acknowledge.
REQ-020 Port done_o, out, 1: one-cycle pulse at burst end.
REQ-021 Port clr_stats_i, in, 1: synchronous clear of statistics.
REQ-022 Port err_cnt_o, out, 16: saturating read-mismatch count.
REQ-023 Port first_err_addr_o, out, AW: address of first mismatch since clear.
REQ-024 Port timeout_o, out, 1: sticky ack-timeout flag.

Function
REQ-025 States: IDLE, BEAT, DONE.
REQ-026 IDLE: cmd_ready_o = 1; cmd_valid_i captures we, addr (bits [1:0] forced 0) and len; next state BEAT.
REQ-027 BEAT: wb_cyc_o = wb_stb_o = 1, wb_sel_o all ones, wb_we_o = captured we; cmd_ready_o = 0.
REQ-028 First beat appears the cycle after acceptance; stb is held steady until ack.
REQ-029 Expected/write data per beat = wb_addr_o XOR SEED, truncated/zero-extended to DW.
REQ-030 On ack with beats remaining: address += SW; data updates next cycle; stb/cyc stay high (back-to-back).
REQ-031 On ack of the last beat (len+1 acks total): next state DONE.
REQ-032 Read ack: wb_dat_i != expected → err_cnt_o += 1, saturating at 16'hFFFF.
REQ-033 On that same mismatch, if err_cnt_o was 0, capture first_err_addr_o.
REQ-034 Timeout counter clears on acceptance and on every ack, and increments each BEAT cycle without ack.
REQ-035 Timeout counter reaching TIMEOUT-1 with no ack: drop cyc/stb, set timeout_o, go to DONE.
REQ-036 Ack coincident with timeout terminal count: ack wins, no timeout.
REQ-037 DONE: cyc/stb low, done_o = 1 for exactly one cycle, then IDLE; command acceptance is earliest the next cycle.
REQ-038 clr_stats_i zeroes err_cnt_o, first_err_addr_o and timeout_o; it has priority over a same-cycle mismatch or timeout.
REQ-039 Address wraps modulo 2^AW; no error is raised on wrap.

Reset
REQ-040 RESETN low immediately forces state IDLE.
REQ-041 Reset values: cyc/stb/we/done_o = 0, wb_addr_o = 0, wb_dat_o = 0, wb_sel_o = 0, err_cnt_o = 0, first_err_addr_o = 0, timeout_o = 0; cmd_ready_o = 1 after release.
REQ-042 Reset mid-burst abandons the burst with no done_o pulse.

Structure
REQ-043 Shared package wb_master_pkg holds the state enum and the pattern function (addr XOR SEED).
REQ-044 One sub-module, wb_ack_watchdog, holds the timeout counter.
REQ-045 Implementation fits in 120–400 lines of RTL.

Verification
REQ-046 Scenario: write len=3 at 0x100, ack each 2nd cycle → addrs 0x100/104/108/10C, data = addr^SEED, done_o 1 pulse.
REQ-047 Scenario: read-back of the same burst from an ideal slave → err_cnt_o = 0.
REQ-048 Scenario: read with beat 2 corrupted → err_cnt_o = 1, first_err_addr_o = 0x108.
REQ-049 Scenario: slave never acks, TIMEOUT=16 → cyc drops 16 cycles after stb rises, timeout_o = 1, done_o pulses.
REQ-050 Scenario: RESETN low during beat 1 → cyc/stb low asynchronously, no done_o, next command runs normally.
REQ-051 Scenario: clr_stats_i coincident with a mismatch → err_cnt_o = 0.

Source files
------------

// File: rtl/wb_master_pkg.sv
// Shared types and the address-derived data pattern for the Wishbone burst master.
package wb_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BEAT = 2'd1,
    ST_DONE = 2'd2
  } wb_state_e;

  // Widest address/data the pattern helper supports; callers cast in and out.
  localparam int PAT_W = 64;

  function automatic logic [PAT_W-1:0] wb_pattern(input logic [PAT_W-1:0] addr,
                                                  input logic [31:0]      seed);
    return addr ^ PAT_W'(seed);
  endfunction

endpackage

// File: rtl/wb_ack_watchdog.sv
// Counts cycles spent waiting for a Wishbone ack and flags the terminal count.
module wb_ack_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  input  logic ack,
  output logic expired
);
  localparam int            CW   = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] TERM = CW'(TIMEOUT - 32'sd1);

  logic [CW-1:0] cnt_r;

  // Wait counter: restarts on every new command and every ack, parks at terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clr || ack) begin
      cnt_r <= '0;
    end else if (run && (cnt_r != TERM)) begin
      cnt_r <= cnt_r + CW'(1'b1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // An ack in the terminal cycle wins over the timeout.
  assign expired = run && !ack && (cnt_r == TERM);

endmodule

// File: rtl/wb_burst_master.sv
// Wishbone classic burst master: writes incrementing bursts of an address-derived
// pattern, or reads them back and keeps mismatch/timeout statistics.
module wb_burst_master
  import wb_master_pkg::*;
#(
  parameter int          DW      = 32,
  parameter int          AW      = 32,
  parameter int          LEN_W   = 8,
  parameter int          TIMEOUT = 1024,
  parameter logic [31:0] SEED    = 32'hA5A5_0000
) (
  input  logic             wb_clk_i,
  input  logic             RESETN,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_we_i,
  input  logic [AW-1:0]    cmd_addr_i,
  input  logic [LEN_W-1:0] cmd_len_i,
  output logic             wb_cyc_o,
  output logic             wb_stb_o,
  output logic             wb_we_o,
  output logic [AW-1:0]    wb_addr_o,
  output logic [DW/8-1:0]  wb_sel_o,
  output logic [DW-1:0]    wb_dat_o,
  input  logic [DW-1:0]    wb_dat_i,
  input  logic             wb_ack_i,
  output logic             done_o,
  input  logic             clr_stats_i,
  output logic [15:0]      err_cnt_o,
  output logic [AW-1:0]    first_err_addr_o,
  output logic             timeout_o
);
  localparam int            SW        = DW / 8;
  localparam logic [AW-1:0] ADDR_MASK = ~AW'(2'b11);
  localparam logic [AW-1:0] ADDR_STEP = AW'(SW);

  wb_state_e        state_r;
  logic             cmd_ready_r;
  logic             cyc_r;
  logic             stb_r;
  logic             we_r;
  logic [AW-1:0]    addr_r;
  logic [SW-1:0]    sel_r;
  logic [DW-1:0]    dat_r;
  logic             done_r;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] beat_r;
  logic [15:0]      err_cnt_r;
  logic [AW-1:0]    first_err_r;
  logic             timeout_r;

  logic             accept_s;
  logic             in_beat_s;
  logic             ack_s;
  logic             last_s;
  logic             mismatch_s;
  logic             expired_s;
  logic [AW-1:0]    start_addr_s;
  logic [AW-1:0]    next_addr_s;
  logic [DW-1:0]    start_dat_s;
  logic [DW-1:0]    next_dat_s;

  assign accept_s     = (state_r == ST_IDLE) && cmd_ready_r && cmd_valid_i;
  assign in_beat_s    = (state_r == ST_BEAT);
  assign ack_s        = in_beat_s && cyc_r && stb_r && wb_ack_i;
  assign last_s       = (beat_r == len_r);
  assign mismatch_s   = ack_s && !we_r && (wb_dat_i != dat_r);
  assign start_addr_s = cmd_addr_i & ADDR_MASK;
  assign next_addr_s  = addr_r + ADDR_STEP;
  // dat_r doubles as the expected read data, so it follows the address in both directions.
  assign start_dat_s  = DW'(wb_pattern(PAT_W'(start_addr_s), SEED));
  assign next_dat_s   = DW'(wb_pattern(PAT_W'(next_addr_s), SEED));

  wb_ack_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (wb_clk_i),
    .rst_n   (RESETN),
    .clr     (accept_s),
    .run     (in_beat_s),
    .ack     (ack_s),
    .expired (expired_s)
  );

  // Burst sequencer with all bus-facing outputs registered.
  always_ff @(posedge wb_clk_i or negedge RESETN) begin
    if (!RESETN) begin
      state_r     <= ST_IDLE;
      cmd_ready_r <= 1'b1;
      cyc_r       <= 1'b0;
      stb_r       <= 1'b0;
      we_r        <= 1'b0;
      addr_r      <= '0;
      sel_r       <= '0;
      dat_r       <= '0;
      done_r      <= 1'b0;
      len_r       <= '0;
      beat_r      <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (accept_s) begin
            state_r     <= ST_BEAT;
            cmd_ready_r <= 1'b0;
            cyc_r       <= 1'b1;
            stb_r       <= 1'b1;
            we_r        <= cmd_we_i;
            addr_r      <= start_addr_s;
            sel_r       <= {SW{1'b1}};
            dat_r       <= start_dat_s;
            len_r       <= cmd_len_i;
            beat_r      <= '0;
          end else begin
            cmd_ready_r <= 1'b1;
          end
        end
        ST_BEAT: begin
          if (ack_s && !last_s) begin
            addr_r <= next_addr_s;
            dat_r  <= next_dat_s;
            beat_r <= beat_r + LEN_W'(1'b1);
          end else if (ack_s || expired_s) begin
            state_r <= ST_DONE;
            cyc_r   <= 1'b0;
            stb_r   <= 1'b0;
            we_r    <= 1'b0;
            sel_r   <= '0;
            done_r  <= 1'b1;
          end else begin
            state_r <= ST_BEAT;
          end
        end
        ST_DONE: begin
          state_r     <= ST_IDLE;
          done_r      <= 1'b0;
          cmd_ready_r <= 1'b1;
        end
        default: begin
          state_r     <= ST_IDLE;
          cyc_r       <= 1'b0;
          stb_r       <= 1'b0;
          we_r        <= 1'b0;
          sel_r       <= '0;
          done_r      <= 1'b0;
          cmd_ready_r <= 1'b1;
        end
      endcase
    end
  end

  // Statistics: the clear dominates any same-cycle mismatch or timeout.
  always_ff @(posedge wb_clk_i or negedge RESETN) begin
    if (!RESETN) begin
      err_cnt_r   <= 16'h0000;
      first_err_r <= '0;
      timeout_r   <= 1'b0;
    end else if (clr_stats_i) begin
      err_cnt_r   <= 16'h0000;
      first_err_r <= '0;
      timeout_r   <= 1'b0;
    end else begin
      if (mismatch_s && (err_cnt_r != 16'hFFFF)) begin
        err_cnt_r <= err_cnt_r + 16'h0001;
      end
      if (mismatch_s && (err_cnt_r == 16'h0000)) begin
        first_err_r <= addr_r;
      end
      if (expired_s) begin
        timeout_r <= 1'b1;
      end
    end
  end

  assign cmd_ready_o      = cmd_ready_r;
  assign wb_cyc_o         = cyc_r;
  assign wb_stb_o         = stb_r;
  assign wb_we_o          = we_r;
  assign wb_addr_o        = addr_r;
  assign wb_sel_o         = sel_r;
  assign wb_dat_o         = dat_r;
  assign done_o           = done_r;
  assign err_cnt_o        = err_cnt_r;
  assign first_err_addr_o = first_err_r;
  assign timeout_o        = timeout_r;

endmodule
